// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signal bundle for mem_arbiter.
// The arbiter binds to the slave modport; caches plus memory form the master side.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128
);
    logic              ic_read_req;
    logic [ADDR_W-1:0] ic_read_addr;
    logic              ic_read_ack;
    logic [LINE_W-1:0] ic_read_data;

    logic              dc_read_req;
    logic [ADDR_W-1:0] dc_read_addr;
    logic              dc_read_ack;
    logic [LINE_W-1:0] dc_read_data;

    logic              dc_write_req;
    logic [ADDR_W-1:0] dc_write_addr;
    logic [LINE_W-1:0] dc_write_data;
    logic              dc_write_ack;

    logic              mem_enable;
    logic              mem_rw;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_data_out;
    logic              mem_ack;
    logic [LINE_W-1:0] mem_data_in;

    modport slave (
        input  ic_read_req, ic_read_addr,
        output ic_read_ack, ic_read_data,
        input  dc_read_req, dc_read_addr,
        output dc_read_ack, dc_read_data,
        input  dc_write_req, dc_write_addr, dc_write_data,
        output dc_write_ack,
        output mem_enable, mem_rw, mem_addr, mem_data_out,
        input  mem_ack, mem_data_in
    );

    modport master (
        output ic_read_req, ic_read_addr,
        input  ic_read_ack, ic_read_data,
        output dc_read_req, dc_read_addr,
        input  dc_read_ack, dc_read_data,
        output dc_write_req, dc_write_addr, dc_write_data,
        input  dc_write_ack,
        input  mem_enable, mem_rw, mem_addr, mem_data_out,
        output mem_ack, mem_data_in
    );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: dcache write-back > dcache fill > icache fill,
// with a streak counter that forces an icache grant after STARVE_MAX dcache wins.
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int LINE_W     = 128,
    parameter int STARVE_MAX = 4
) (
    input logic          clk,
    input logic          reset,
    mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic [1:0] {OWN_IC, OWN_DR, OWN_DW} owner_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t            state, state_nxt;
    owner_t            owner, winner;
    logic              grant;
    logic [3:0]        streak, streak_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic              rw_q;
    logic [LINE_W-1:0] wdata_q;
    logic [LINE_W-1:0] ic_line, dc_line;
    logic              any_req, starved;

    assign any_req = bus.ic_read_req | bus.dc_read_req | bus.dc_write_req;
    assign starved = bus.ic_read_req && (streak == STARVE_LIM);

    always_comb begin
        state_nxt  = state;
        streak_nxt = streak;
        winner     = OWN_IC;
        grant      = 1'b0;
        unique case (state)
            IDLE: begin
                if (any_req) begin
                    grant     = 1'b1;
                    state_nxt = BUSY;
                    if (starved)               winner = OWN_IC;
                    else if (bus.dc_write_req) winner = OWN_DW;
                    else if (bus.dc_read_req)  winner = OWN_DR;
                    else                       winner = OWN_IC;
                    // Streak only grows while the icache is actually left waiting.
                    if (winner == OWN_IC || !bus.ic_read_req)
                        streak_nxt = '0;
                    else if (streak != STARVE_LIM)
                        streak_nxt = streak + 4'd1;
                end
            end
            BUSY: begin
                if (bus.mem_ack) state_nxt = DONE;
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            owner   <= OWN_IC;
            streak  <= '0;
            addr_q  <= '0;
            rw_q    <= 1'b0;
            wdata_q <= '0;
            ic_line <= '0;
            dc_line <= '0;
        end else begin
            state  <= state_nxt;
            streak <= streak_nxt;
            if (grant) begin
                owner <= winner;
                unique case (winner)
                    OWN_DW: begin
                        addr_q  <= bus.dc_write_addr;
                        rw_q    <= 1'b1;
                        wdata_q <= bus.dc_write_data;
                    end
                    OWN_DR: begin
                        addr_q  <= bus.dc_read_addr;
                        rw_q    <= 1'b0;
                        wdata_q <= '0;
                    end
                    default: begin
                        addr_q  <= bus.ic_read_addr;
                        rw_q    <= 1'b0;
                        wdata_q <= '0;
                    end
                endcase
            end
            // Fill lines update only here, so *_data holds between acks.
            if (state == BUSY && bus.mem_ack) begin
                if (owner == OWN_IC)      ic_line <= bus.mem_data_in;
                else if (owner == OWN_DR) dc_line <= bus.mem_data_in;
            end
        end
    end

    always_comb begin
        bus.mem_enable   = (state == BUSY);
        bus.mem_rw       = (state == BUSY) && rw_q;
        bus.mem_addr     = (state == BUSY) ? addr_q  : '0;
        bus.mem_data_out = (state == BUSY) ? wdata_q : '0;
        bus.ic_read_ack  = (state == DONE) && (owner == OWN_IC);
        bus.dc_read_ack  = (state == DONE) && (owner == OWN_DR);
        bus.dc_write_ack = (state == DONE) && (owner == OWN_DW);
        bus.ic_read_data = ic_line;
        bus.dc_read_data = dc_line;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: an environment process models arbitration
// and memory, a separate monitor pops expectations when the DUT responds.
`timescale 1ns/1ps
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int LW = 128;
    localparam int SM = 4;
    localparam int OWN_IC = 0;
    localparam int OWN_DR = 1;
    localparam int OWN_DW = 2;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    mem_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) bus ();
    mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .STARVE_MAX(SM)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          owner;
        logic [AW-1:0] addr;
        logic        rw;
        logic [LW-1:0] wdata;
        int          dcyc;
    } grant_t;
    typedef struct {
        int          owner;
        logic [LW-1:0] data;
    } ack_t;

    grant_t grant_q[$];
    ack_t   ack_q[$];

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [LW-1:0] rnd_line();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Environment knobs set by the stimulus process.
    int            force_wait  = -1;
    bit            spurious_en = 1'b0;
    bit            force_line_en = 1'b0;
    logic [LW-1:0] force_line  = {16{8'hA5}};

    // Reference model: the arbiter is free, picks by priority/starvation, is busy
    // until memory acks, then free again two cycles after that ack.
    bit     m_free   = 1'b1;
    int     free_in  = 0;
    int     streak_m = 0;
    bit     mem_busy = 1'b0;
    int     wait_cnt = 0;
    int     cur_owner = 0;
    int     win;
    grant_t g_tmp;
    ack_t   a_tmp;

    always @(negedge clk) begin
        if (!reset) begin
            m_free = 1'b1; free_in = 0; streak_m = 0; mem_busy = 1'b0;
            bus.mem_ack = 1'b0;
            grant_q.delete();
            ack_q.delete();
        end else begin
            bus.mem_ack = 1'b0;
            if (free_in > 0) begin
                free_in--;
                if (free_in == 0) m_free = 1'b1;
            end
            if (mem_busy && bus.mem_enable) begin
                if (wait_cnt == 0) begin
                    a_tmp.owner = cur_owner;
                    a_tmp.data  = force_line_en ? force_line : rnd_line();
                    bus.mem_ack     = 1'b1;
                    bus.mem_data_in = a_tmp.data;
                    ack_q.push_back(a_tmp);
                    mem_busy = 1'b0;
                    free_in  = 2;
                end else begin
                    wait_cnt--;
                end
            end else if (!mem_busy && spurious_en && $urandom_range(0, 3) == 0) begin
                bus.mem_ack     = 1'b1;
                bus.mem_data_in = rnd_line();
            end
            if (m_free && (bus.ic_read_req || bus.dc_read_req || bus.dc_write_req)) begin
                if (streak_m == SM && bus.ic_read_req) win = OWN_IC;
                else if (bus.dc_write_req)             win = OWN_DW;
                else if (bus.dc_read_req)              win = OWN_DR;
                else                                   win = OWN_IC;
                if (win == OWN_IC || !bus.ic_read_req) streak_m = 0;
                else if (streak_m < SM)                streak_m++;
                g_tmp.owner = win;
                g_tmp.addr  = (win == OWN_IC) ? bus.ic_read_addr :
                              (win == OWN_DR) ? bus.dc_read_addr : bus.dc_write_addr;
                g_tmp.rw    = (win == OWN_DW);
                g_tmp.wdata = (win == OWN_DW) ? bus.dc_write_data : '0;
                g_tmp.dcyc  = cyc;
                grant_q.push_back(g_tmp);
                m_free    = 1'b0;
                mem_busy  = 1'b1;
                cur_owner = win;
                wait_cnt  = (force_wait >= 0) ? force_wait : $urandom_range(0, 3);
            end
        end
    end

    // Monitor: samples after the environment has settled within the low phase.
    bit            prev_en  = 1'b0;
    bit            prev_hit = 1'b0;
    int            low_cnt  = 100;
    int            n_ack;
    int            who;
    logic [AW-1:0] cur_addr;
    logic          cur_rw;
    logic [LW-1:0] cur_wd;
    logic [LW-1:0] exp_ic_line = '0;
    logic [LW-1:0] exp_dc_line = '0;
    grant_t        g_mon;
    ack_t          a_mon;

    always @(negedge clk) begin
        #2;
        if (!reset) begin
            prev_en = 1'b0; prev_hit = 1'b0; low_cnt = 100;
            exp_ic_line = '0; exp_dc_line = '0;
        end else begin
            n_ack = int'(bus.ic_read_ack) + int'(bus.dc_read_ack) + int'(bus.dc_write_ack);
            if (n_ack > 1) chk("single_ack", LW'(n_ack), LW'(1));
            if (prev_hit || n_ack != 0) begin
                chk("ack_follows_mem_ack", LW'(n_ack != 0), LW'(prev_hit));
                if (n_ack != 0) begin
                    if (ack_q.size() == 0) begin
                        chk("ack_expected", LW'(n_ack), LW'(0));
                    end else begin
                        a_mon = ack_q.pop_front();
                        who = bus.ic_read_ack ? OWN_IC : bus.dc_read_ack ? OWN_DR : OWN_DW;
                        chk("ack_owner", LW'(who), LW'(a_mon.owner));
                        if (a_mon.owner == OWN_IC) exp_ic_line = a_mon.data;
                        if (a_mon.owner == OWN_DR) exp_dc_line = a_mon.data;
                    end
                end
            end
            chk("ic_read_data", bus.ic_read_data, exp_ic_line);
            chk("dc_read_data", bus.dc_read_data, exp_dc_line);

            if (bus.mem_enable && !prev_en) begin
                chk("enable_gap", LW'(low_cnt >= 2), LW'(1));
                if (grant_q.size() == 0) begin
                    chk("grant_expected", LW'(1), LW'(0));
                end else begin
                    g_mon = grant_q.pop_front();
                    chk("mem_addr",     LW'(bus.mem_addr), LW'(g_mon.addr));
                    chk("mem_rw",       LW'(bus.mem_rw),   LW'(g_mon.rw));
                    chk("mem_data_out", bus.mem_data_out,  g_mon.wdata);
                    chk("grant_latency", LW'(cyc), LW'(g_mon.dcyc + 1));
                end
                cur_addr = bus.mem_addr; cur_rw = bus.mem_rw; cur_wd = bus.mem_data_out;
            end else if (bus.mem_enable) begin
                chk("stable_addr", LW'(bus.mem_addr), LW'(cur_addr));
                chk("stable_rw",   LW'(bus.mem_rw),   LW'(cur_rw));
                chk("stable_data", bus.mem_data_out,  cur_wd);
            end
            if (bus.mem_enable) low_cnt = 0;
            else                low_cnt++;
            prev_hit = bus.mem_enable && bus.mem_ack;
            prev_en  = bus.mem_enable;
        end
    end

    // Requester helpers.
    task automatic raise(input int r);
        case (r)
            OWN_IC: begin bus.ic_read_req = 1'b1; bus.ic_read_addr = $urandom(); end
            OWN_DR: begin bus.dc_read_req = 1'b1; bus.dc_read_addr = $urandom(); end
            default: begin
                bus.dc_write_req  = 1'b1;
                bus.dc_write_addr = $urandom();
                bus.dc_write_data = rnd_line();
            end
        endcase
    endtask

    task automatic drop(input int r);
        case (r)
            OWN_IC:  bus.ic_read_req  = 1'b0;
            OWN_DR:  bus.dc_read_req  = 1'b0;
            default: bus.dc_write_req = 1'b0;
        endcase
    endtask

    function automatic bit any_req();
        return bus.ic_read_req || bus.dc_read_req || bus.dc_write_req;
    endfunction

    int ack_cyc;
    task automatic step(output bit [2:0] a);
        @(negedge clk);
        a = {bus.dc_write_ack, bus.dc_read_ack, bus.ic_read_ack};
        ack_cyc = cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #2 reset = 1'b0;
        @(posedge clk); #2 reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic serve(input int r, input int bound, output int lat, output bit [2:0] at_ack);
        bit [2:0] a;
        int t0;
        bit got;
        t0 = cyc; lat = -1; at_ack = '0; got = 1'b0;
        for (int i = 0; i < bound && !got; i++) begin
            step(a);
            if (a[r]) begin
                got = 1'b1; lat = ack_cyc - t0; at_ack = a;
                drop(r);
            end
        end
    endtask

    task automatic drain();
        bit [2:0] a;
        for (int i = 0; i < 100 && any_req(); i++) begin
            step(a);
            for (int r = 0; r < 3; r++) if (a[r]) drop(r);
        end
        for (int i = 0; i < 4; i++) step(a);
        chk("drain_done", LW'(any_req()), LW'(0));
    endtask

    initial begin
        bit [2:0] a;
        int lat, n, cnt, n_ic;
        int order[3];
        bit ok, dw_seen, got_ic;

        bus.ic_read_req = 0; bus.ic_read_addr = '0;
        bus.dc_read_req = 0; bus.dc_read_addr = '0;
        bus.dc_write_req = 0; bus.dc_write_addr = '0; bus.dc_write_data = '0;
        bus.mem_ack = 0; bus.mem_data_in = '0;

        // Reset state.
        @(negedge clk); @(negedge clk);
        chk("reset_outputs", LW'({bus.mem_enable, bus.mem_rw, |bus.mem_addr, |bus.mem_data_out,
                                  bus.ic_read_ack, bus.dc_read_ack, bus.dc_write_ack,
                                  |bus.ic_read_data, |bus.dc_read_data}), LW'(0));
        @(posedge clk); #2 reset = 1'b1;
        @(posedge clk); #1;

        // Single icache fill, memory acks 3 cycles after enable.
        force_wait = 3; force_line_en = 1'b1;
        raise(OWN_IC); bus.ic_read_addr = 32'h100;
        serve(OWN_IC, 20, lat, a);
        chk("ic_fill_latency", LW'(lat), LW'(5));
        chk("ic_fill_only_ack", LW'(a), LW'(3'b001));
        chk("ic_fill_data", bus.ic_read_data, {16{8'hA5}});
        force_line_en = 1'b0;
        drain();

        // Zero-wait memory with spurious mem_ack outside BUSY.
        force_wait = 0; spurious_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            raise(k % 2 == 0 ? OWN_DR : OWN_DW);
            serve(k % 2 == 0 ? OWN_DR : OWN_DW, 20, lat, a);
            chk("zero_wait_latency", LW'(lat), LW'(2));
            step(a); step(a);
        end
        spurious_en = 1'b0; force_wait = -1;
        drain();

        // Priority with simultaneous requests.
        pulse_reset();
        raise(OWN_IC); raise(OWN_DR); raise(OWN_DW);
        order = '{-1, -1, -1}; n = 0;
        for (int i = 0; i < 60 && n < 3; i++) begin
            step(a);
            for (int r = 0; r < 3; r++) if (a[r] && n < 3) begin order[n] = r; n++; drop(r); end
        end
        chk("prio_first",  LW'(order[0]), LW'(OWN_DW));
        chk("prio_second", LW'(order[1]), LW'(OWN_DR));
        chk("prio_third",  LW'(order[2]), LW'(OWN_IC));
        drain();

        // Starvation: icache held, dcache fill re-raised after every ack.
        pulse_reset();
        raise(OWN_IC); raise(OWN_DR);
        cnt = 0; n_ic = 0;
        for (int i = 0; i < 200 && n_ic < 2; i++) begin
            step(a);
            if (a[OWN_DR]) begin cnt++; raise(OWN_DR); end
            if (a[OWN_IC]) begin
                chk("starve_dc_grants", LW'(cnt), LW'(SM));
                cnt = 0; n_ic++; raise(OWN_IC);
            end
        end
        chk("starve_ic_grants", LW'(n_ic), LW'(2));
        drop(OWN_DR);
        drain();

        // Reset during a dcache write-back.
        force_wait = 6;
        raise(OWN_DW);
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin step(a); ok = bus.mem_enable; end
        chk("rst_busy_reached", LW'(ok), LW'(1));
        raise(OWN_IC);
        step(a);
        #1 reset = 1'b0;
        #1 chk("rst_async_outputs", LW'({bus.mem_enable, bus.mem_rw, |bus.mem_addr, |bus.mem_data_out,
                                        bus.ic_read_ack, bus.dc_read_ack, bus.dc_write_ack,
                                        |bus.ic_read_data, |bus.dc_read_data}), LW'(0));
        drop(OWN_DW);
        @(posedge clk); #2 reset = 1'b1;
        @(posedge clk); #1;
        force_wait = -1;
        dw_seen = 1'b0; got_ic = 1'b0;
        for (int i = 0; i < 20 && !got_ic; i++) begin
            step(a);
            if (a[OWN_DW]) dw_seen = 1'b1;
            if (a[OWN_IC]) begin got_ic = 1'b1; drop(OWN_IC); end
        end
        chk("rst_no_dw_ack", LW'(dw_seen), LW'(0));
        chk("rst_ic_served", LW'(got_ic), LW'(1));
        drain();

        // Randomized traffic.
        spurious_en = 1'b1;
        for (int i = 0; i < 600; i++) begin
            step(a);
            for (int r = 0; r < 3; r++) begin
                if (a[r]) begin
                    drop(r);
                    if ($urandom_range(0, 3) == 0) raise(r);
                end else if (!(r == OWN_IC ? bus.ic_read_req : r == OWN_DR ? bus.dc_read_req
                                                                          : bus.dc_write_req)
                             && $urandom_range(0, 2) == 0) begin
                    raise(r);
                end
            end
        end
        spurious_en = 1'b0;
        drain();
        chk("grant_q_empty", LW'(grant_q.size()), LW'(0));
        chk("ack_q_empty",   LW'(ack_q.size()),   LW'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
